operand_entry: RTL and testbench
================================

Name: operand_entry

Overview:
- Upstream input stage of the calculator datapath.
- Synchronises and debounces the ENTER and CLEAR push-buttons.
- Sequences the user through operand-1 entry, operand-2 entry and result display.
- Drives registered op1/op2/operation/sign straight into the calculator top level, which feeds miniAlu.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable synchronised cycles required before a button level is accepted; legal range >= 2; counter width $clog2(DEBOUNCE_CYCLES).
SYNC_STAGES, 2, flip-flop depth of each button synchroniser; legal range >= 2.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
sw  input  4  raw switch value for the operand being entered; quasi-static, not synchronised
sw_operation  input  1  raw operation-select switch
sw_sign  input  1  raw signed/unsigned switch
btn_enter  input  1  raw ENTER push-button, active-high, bouncy
btn_clear  input  1  raw CLEAR push-button, active-high, bouncy
op1  output  4  registered operand 1
op2  output  4  registered operand 2
operation  output  1  registered operation select
sign  output  1  registered sign mode
phase  output  2  FSM state: 0=S_OP1, 1=S_OP2, 2=S_RESULT; 3 never driven
result_valid  output  1  high while phase==S_RESULT

Behaviour:
- Reset (async assert, sync release):
  - op1=0, op2=0, operation=0, sign=0, phase=S_OP1, result_valid=0.
  - Synchronisers, debounced levels and counters all cleared to 0.
- Synchroniser: each button passes through SYNC_STAGES flops. The output is the synced level.
- Debouncer, per button:
  - Counter clears whenever synced == debounced.
  - Otherwise the counter increments. When counter == DEBOUNCE_CYCLES-1 and synced still differs, debounced <= synced and counter <= 0.
  - Any return to the debounced level before then restarts the count.
- Press pulse:
  - press = debounced & ~debounced_q, where debounced_q is a 1-cycle delay. Exactly one cycle high per accepted rising level.
  - Holding a button produces no further pulses.
  - Release produces no pulse.
- Latency: raw ENTER edge to register update = SYNC_STAGES + DEBOUNCE_CYCLES + 1 rising edges.
- FSM, evaluated on each edge:
  - S_OP1, enter_press: op1 <= sw; -> S_OP2.
  - S_OP2, enter_press: op2 <= sw; operation <= sw_operation; sign <= sw_sign; -> S_RESULT.
  - S_RESULT, enter_press: op1 <= sw; -> S_OP2 (new calculation). op2, operation and sign hold their old values until recaptured.
  - clear_press in any state: op1, op2, operation and sign <= 0; -> S_OP1.
  - clear_press and enter_press in the same cycle: clear wins, enter is discarded.
- Registered outputs hold their values in all cycles without a qualifying press.
- result_valid is a registered decode of phase (phase==S_RESULT). It changes on the same edge as phase.
- Switch inputs are sampled only on the capture edge. They are assumed stable across a press and are not synchronised.
- Reset asserted mid-debounce discards the pending count. No pulse follows deassertion unless the button is held a full DEBOUNCE_CYCLES again.

Optional Feature:
DEBOUNCE_BYPASS_EN:
- Defined: debounce counters are removed and debounced = synced directly.
  - Latency = SYNC_STAGES + 1 edges.
  - Intended for fast simulation and board bring-up. Bounces produce multiple pulses.
- Undefined: full debounce as specified above.
- FSM, clear priority and reset behaviour are identical in both builds.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, SYNC_STAGES=2, with DEBOUNCE_BYPASS_EN undefined.
1. Assert rst mid-simulation with op1=7 loaded -> op1, op2, operation, sign, result_valid = 0 and phase=0 immediately (async), before the next clk edge.
2. sw=5, hold btn_enter 10 cycles -> op1=5, phase=1 exactly 7 edges after the raw assertion; no second capture while held. Release, then sw=3, sw_operation=1, sw_sign=1, press -> op2=3, operation=1, sign=1, phase=2, result_valid=1.
3. In S_OP1, toggle btn_enter every 2 cycles for 16 cycles then hold low -> no press; op1 unchanged, phase stays 0.
4. In S_OP2, raise btn_enter and btn_clear on the same cycle, hold 10 -> phase=0 and all operands 0 on the same edge; enter ignored.
5. From S_RESULT (op1=5, op2=3), sw=9, press enter -> op1=9, op2 stays 3, phase=1, result_valid=0.
6. Hold btn_enter 3 cycles past sync, pulse rst, keep btn_enter high 2 more cycles then release -> no capture, phase=0. Rebuild with DEBOUNCE_BYPASS_EN: a single 1-cycle btn_enter pulse -> capture 3 edges later.

Source files
------------

// File: rtl/operand_entry.sv
// ---------------------------------------------------------------------------
// operand_entry
//
// Input stage of the calculator datapath. It synchronises and debounces the
// ENTER and CLEAR push-buttons, then steps the user through three phases:
// entering operand 1, entering operand 2 (plus the operation and sign
// switches), and showing the result. The operand, operation and sign
// registers feed the calculator top level directly.
//
// Optional build macro:
//   DEBOUNCE_BYPASS_EN - when defined, the debounce counters are removed and
//                        each synchronised level is used as the debounced
//                        level. Raw press to capture then takes SYNC_STAGES+1
//                        edges, and bounces produce multiple presses.
//
// Parameters:
//   DEBOUNCE_CYCLES - number of stable synchronised cycles needed before a
//                     new button level is accepted (>= 2)
//   SYNC_STAGES     - flip-flop depth of each button synchroniser (>= 2)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset (released synchronously
//                     upstream)
//   sw[3:0]      in   raw operand switches, sampled on the capture edge
//   sw_operation in   raw operation-select switch
//   sw_sign      in   raw signed/unsigned switch
//   btn_enter    in   raw ENTER button, active-high, bouncy
//   btn_clear    in   raw CLEAR button, active-high, bouncy
//   op1[3:0]     out  registered operand 1
//   op2[3:0]     out  registered operand 2
//   operation    out  registered operation select
//   sign         out  registered sign mode
//   phase[1:0]   out  0 = operand 1 entry, 1 = operand 2 entry, 2 = result
//   result_valid out  registered, high while phase is the result phase
// ---------------------------------------------------------------------------
module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       sw_operation,
  input  logic       sw_sign,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [3:0] op1,
  output logic [3:0] op2,
  output logic       operation,
  output logic       sign,
  output logic [1:0] phase,
  output logic       result_valid
);

  localparam logic [1:0] S_OP1    = 2'd0;
  localparam logic [1:0] S_OP2    = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;

  localparam int BTN_ENTER = 0;
  localparam int BTN_CLEAR = 1;

  logic [1:0] btn_raw;
  logic [1:0] btn_press;

  assign btn_raw = {btn_clear, btn_enter};

  // -------------------------------------------------------------------------
  // Per-button conditioning: synchroniser, debouncer, rising-edge pulse.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   synced;
      logic                   debounced;
      logic                   debounced_dly_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[gi]};
        end
      end

      assign synced = sync_q[SYNC_STAGES-1];

`ifdef DEBOUNCE_BYPASS_EN
      assign debounced = synced;
`else
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             debounced_q;
      logic             debounced_d;

      // The counter only runs while the synchronised level disagrees with
      // the accepted level; any agreement restarts the stability window.
      always_comb begin
        cnt_d       = cnt_q;
        debounced_d = debounced_q;
        if (synced == debounced_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          debounced_d = synced;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q       <= '0;
          debounced_q <= 1'b0;
        end else begin
          cnt_q       <= cnt_d;
          debounced_q <= debounced_d;
        end
      end

      assign debounced = debounced_q;
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          debounced_dly_q <= 1'b0;
        end else begin
          debounced_dly_q <= debounced;
        end
      end

      // One-cycle pulse on each accepted rising level; hold and release are
      // silent.
      assign btn_press[gi] = debounced & ~debounced_dly_q;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Entry sequencer
  // -------------------------------------------------------------------------
  logic [3:0] op1_q, op1_d;
  logic [3:0] op2_q, op2_d;
  logic       operation_q, operation_d;
  logic       sign_q, sign_d;
  logic [1:0] phase_q, phase_d;
  logic       result_valid_q, result_valid_d;

  always_comb begin
    op1_d       = op1_q;
    op2_d       = op2_q;
    operation_d = operation_q;
    sign_d      = sign_q;
    phase_d     = phase_q;

    // CLEAR has priority; a simultaneous ENTER is dropped.
    if (btn_press[BTN_CLEAR]) begin
      op1_d       = '0;
      op2_d       = '0;
      operation_d = 1'b0;
      sign_d      = 1'b0;
      phase_d     = S_OP1;
    end else if (btn_press[BTN_ENTER]) begin
      case (phase_q)
        S_OP1: begin
          op1_d   = sw;
          phase_d = S_OP2;
        end
        S_OP2: begin
          op2_d       = sw;
          operation_d = sw_operation;
          sign_d      = sw_sign;
          phase_d     = S_RESULT;
        end
        S_RESULT: begin
          // New calculation: op2/operation/sign keep their old values until
          // recaptured in the operand 2 phase.
          op1_d   = sw;
          phase_d = S_OP2;
        end
        default: begin
          phase_d = S_OP1;
        end
      endcase
    end

    // Decoded from the next phase so the flag moves on the same edge.
    result_valid_d = (phase_d == S_RESULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q          <= '0;
      op2_q          <= '0;
      operation_q    <= 1'b0;
      sign_q         <= 1'b0;
      phase_q        <= S_OP1;
      result_valid_q <= 1'b0;
    end else begin
      op1_q          <= op1_d;
      op2_q          <= op2_d;
      operation_q    <= operation_d;
      sign_q         <= sign_d;
      phase_q        <= phase_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign op1          = op1_q;
  assign op2          = op2_q;
  assign operation    = operation_q;
  assign sign         = sign_q;
  assign phase        = phase_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_operand_entry.sv
// ---------------------------------------------------------------------------
// tb_operand_entry
//
// Scoreboard bench for operand_entry with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// A reference model samples the raw buttons on every rising edge, decides
// when a level has been held long enough to be accepted, schedules the
// resulting press and pushes the expected output snapshot (and the edge it
// must appear on) into a queue. A monitor on the falling edge pops an entry
// whenever the outputs change and compares.
// ---------------------------------------------------------------------------
module tb_operand_entry;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
`ifdef DEBOUNCE_BYPASS_EN
  localparam int RUN_LEN   = 1;
  localparam int PRESS_LAG = SYNC;
`else
  localparam int RUN_LEN   = DEB;
  localparam int PRESS_LAG = SYNC + 1;
`endif

  typedef struct packed {
    logic [3:0] op1;
    logic [3:0] op2;
    logic       operation;
    logic       sign;
    logic [1:0] phase;
    logic       rv;
  } snap_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sw = '0;
  logic       sw_operation = 1'b0;
  logic       sw_sign = 1'b0;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] op1;
  logic [3:0] op2;
  logic       operation;
  logic       sign;
  logic [1:0] phase;
  logic       result_valid;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  snap_t exp_q[$];
  int    edge_q[$];

  operand_entry #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .sw_operation(sw_operation),
    .sw_sign     (sw_sign),
    .btn_enter   (btn_enter),
    .btn_clear   (btn_clear),
    .op1         (op1),
    .op2         (op2),
    .operation   (operation),
    .sign        (sign),
    .phase       (phase),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  initial begin
    snap_t m, nx;
    logic [1:0] acc;
    int run [2];
    int press_at [2];
    logic lvl;
    m = '0; acc = '0;
    run[0] = 0; run[1] = 0; press_at[0] = -1; press_at[1] = -1;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m = '0; acc = '0;
        run[0] = 0; run[1] = 0; press_at[0] = -1; press_at[1] = -1;
      end else begin
        cyc = cyc + 1;
        nx = m;
        if (press_at[1] == cyc) begin
          nx = '0;
        end else if (press_at[0] == cyc) begin
          if (m.phase == 2'd0 || m.phase == 2'd2) begin
            nx.op1 = sw;
            nx.phase = 2'd1;
          end else begin
            nx.op2 = sw;
            nx.operation = sw_operation;
            nx.sign = sw_sign;
            nx.phase = 2'd2;
          end
        end
        nx.rv = (nx.phase == 2'd2);
        if (nx != m) begin
          exp_q.push_back(nx);
          edge_q.push_back(cyc);
        end
        m = nx;
        // A level is accepted after RUN_LEN consecutive raw samples that
        // differ from the currently accepted level.
        for (int b = 0; b < 2; b++) begin
          lvl = (b == 0) ? btn_enter : btn_clear;
          if (lvl != acc[b]) run[b] = run[b] + 1;
          else run[b] = 0;
          if (run[b] == RUN_LEN) begin
            acc[b] = lvl;
            run[b] = 0;
            if (lvl) press_at[b] = cyc + PRESS_LAG;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    snap_t last, cur, e;
    int en;
    last = '0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        last = '0;
        exp_q.delete();
        edge_q.delete();
      end else begin
        cur = {op1, op2, operation, sign, phase, result_valid};
        if (cur != last) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_update edge=%0d got op1=%0d op2=%0d opr=%0d sgn=%0d ph=%0d rv=%0d required no change",
                     cyc, cur.op1, cur.op2, cur.operation, cur.sign, cur.phase, cur.rv);
          end else begin
            e  = exp_q.pop_front();
            en = edge_q.pop_front();
            if (cur != e || en != cyc) begin
              fails++;
              $display("FAIL update edge=%0d got op1=%0d op2=%0d opr=%0d sgn=%0d ph=%0d rv=%0d required edge=%0d op1=%0d op2=%0d opr=%0d sgn=%0d ph=%0d rv=%0d",
                       cyc, cur.op1, cur.op2, cur.operation, cur.sign, cur.phase, cur.rv,
                       en, e.op1, e.op2, e.operation, e.sign, e.phase, e.rv);
            end else begin
              $display("[TB] edge %0d update op1=%0d op2=%0d opr=%0d sgn=%0d ph=%0d rv=%0d ok",
                       cyc, cur.op1, cur.op2, cur.operation, cur.sign, cur.phase, cur.rv);
            end
          end
        end else if (edge_q.size() > 0 && edge_q[0] < cyc) begin
          tests++;
          fails++;
          e  = exp_q.pop_front();
          en = edge_q.pop_front();
          $display("FAIL missed_update edge=%0d got op1=%0d ph=%0d required at edge %0d op1=%0d op2=%0d ph=%0d",
                   cyc, cur.op1, cur.phase, en, e.op1, e.op2, e.phase);
        end
        last = cur;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_zero(input string name);
    tests++;
    if ({op1, op2, operation, sign, phase, result_valid} != 14'd0) begin
      fails++;
      $display("FAIL %s got op1=%0d op2=%0d opr=%0d sgn=%0d ph=%0d rv=%0d required all zero",
               name, op1, op2, operation, sign, phase, result_valid);
    end else begin
      $display("[TB] %s: outputs zero ok", name);
    end
  endtask

  // Assert reset between edges, check it acts without a clock, release it
  // on the next falling edge.
  task automatic pulse_reset(input string name);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero(name);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press_enter(input logic [3:0] v, input logic opr, input logic sgn,
                             input int hold);
    @(negedge clk);
    sw = v; sw_operation = opr; sw_sign = sgn;
    btn_enter = 1'b1;
    repeat (hold) @(negedge clk);
    btn_enter = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check_zero("power_on_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Load op1=7, then an asynchronous reset mid-run.
    press_enter(4'd7, 1'b0, 1'b0, 6);
    pulse_reset("async_reset_op1_7");
    repeat (3) @(negedge clk);

    // Long hold captures once; then operand 2 with op/sign set.
    press_enter(4'd5, 1'b0, 1'b0, 10);
    press_enter(4'd3, 1'b1, 1'b1, 6);

    // From the result phase a new calculation starts.
    press_enter(4'd9, 1'b0, 1'b0, 6);

    // In operand 2 phase: ENTER and CLEAR together, CLEAR wins.
    @(negedge clk);
    sw = 4'd12;
    btn_enter = 1'b1; btn_clear = 1'b1;
    repeat (10) @(negedge clk);
    btn_enter = 1'b0; btn_clear = 1'b0;
    repeat (10) @(negedge clk);

    // Bouncing ENTER (2-cycle runs) must never be accepted.
    sw = 4'd6;
    for (int i = 0; i < 8; i++) begin
      btn_enter = ~btn_enter;
      repeat (2) @(negedge clk);
    end
    btn_enter = 1'b0;
    repeat (10) @(negedge clk);

    // Reset in the middle of a debounce window discards it.
    btn_enter = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    pulse_reset("reset_mid_debounce");
    repeat (2) @(negedge clk);
    btn_enter = 1'b0;
    repeat (10) @(negedge clk);

    // Single-cycle pulse: ignored when debounced, captured when bypassed.
    sw = 4'd10;
    btn_enter = 1'b1;
    @(negedge clk);
    btn_enter = 1'b0;
    repeat (10) @(negedge clk);

    // Randomised button traffic with varying run lengths.
    for (int s = 0; s < 250; s++) begin
      btn_enter    = 1'($urandom_range(0, 1));
      btn_clear    = ($urandom_range(0, 5) == 0);
      sw           = 4'($urandom);
      sw_operation = 1'($urandom);
      sw_sign      = 1'($urandom);
      repeat ($urandom_range(1, 8)) @(negedge clk);
    end
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (20) @(negedge clk);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
